// File: rtl/control_sequencer.sv
// Registered instruction decoder and beat sequencer for the vector core: decodes
// instruction fields into datapath controls and issues them as one or VLEN/LANES beats.
module control_sequencer #(
  parameter int VLEN  = 16,
  parameter int LANES = 4,
  parameter int BW    = ((VLEN / LANES) > 1) ? $clog2(VLEN / LANES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    instruction_type,
  input  logic [1:0]    func,
  input  logic          imm,
  input  logic          vector,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          stall,
  input  logic          flush,
  output logic          ctrl_valid,
  output logic          JumpI,
  output logic          JumpCI,
  output logic          JumpCD,
  output logic          MemToReg,
  output logic          MemWrite,
  output logic          ImmSrc,
  output logic          VectorOp,
  output logic          ALUSrc1,
  output logic          ALUSrc2,
  output logic          RegVWrite,
  output logic          RegSWrite,
  output logic [1:0]    ALUOp,
  output logic [1:0]    ALUSrc3,
  output logic [BW-1:0] beat_idx,
  output logic          last_beat,
  output logic          illegal
);

  localparam int BEATS = VLEN / LANES;
  localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, SCALAR, VECTOR} state_t;

  typedef struct packed {
    logic       jump_i;
    logic       jump_ci;
    logic       jump_cd;
    logic       mem_to_reg;
    logic       mem_write;
    logic       imm_src;
    logic       vector_op;
    logic       alu_src1;
    logic       alu_src2;
    logic       reg_v_write;
    logic       reg_s_write;
    logic [1:0] alu_op;
    logic [1:0] alu_src3;
  } ctrl_t;

  state_t        state_reg;
  ctrl_t         ctrl_reg;
  ctrl_t         dec;
  logic          dec_illegal;
  logic [BW-1:0] beat_reg;
  logic          last_reg;
  logic          valid_reg;
  logic          illegal_reg;
  logic          ready_en_reg;
  logic          accept;

  // Field decode; anything not matched below is an undefined encoding.
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    case (instruction_type)
      2'b00: begin
        if (func == 2'b00 && !imm) begin
          dec.jump_ci  = 1'b1;
          dec.imm_src  = 1'b1;
          dec.alu_src3 = 2'b11;
          dec.alu_op   = 2'b01;
        end else if (func == 2'b00 && imm) begin
          dec.jump_i = 1'b1;
        end else if (func == 2'b01 && !imm) begin
          dec.jump_cd  = 1'b1;
          dec.imm_src  = 1'b1;
          dec.alu_src3 = 2'b11;
          dec.alu_op   = 2'b01;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      2'b01: begin
        if (func[1]) begin
          dec_illegal = 1'b1;
        end else begin
          dec.imm_src   = 1'b1;
          dec.alu_src3  = 2'b10;
          dec.alu_src1  = vector;
          dec.vector_op = vector;
          if (func[0]) begin
            dec.mem_to_reg  = 1'b1;
            dec.reg_s_write = ~vector;
            dec.reg_v_write = vector;
          end else begin
            dec.mem_write = 1'b1;
          end
        end
      end
      2'b10: begin
        if (!imm) begin
          if (func == 2'b11 || (func == 2'b10 && !vector)) begin
            dec_illegal = 1'b1;
          end else begin
            dec.alu_src3    = 2'b01;
            dec.alu_op      = func;
            dec.alu_src2    = vector;
            dec.vector_op   = vector;
            dec.reg_s_write = ~vector;
            dec.reg_v_write = vector;
          end
        end else if (vector) begin
          dec_illegal = 1'b1;
        end else begin
          dec.alu_src3    = 2'b10;
          dec.imm_src     = 1'b1;
          dec.reg_s_write = 1'b1;
          dec.alu_op      = func;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // ready_en_reg keeps instr_ready low while reset is held and for the release cycle.
  assign instr_ready = ready_en_reg & ((state_reg == IDLE) | (~stall & last_reg));
  assign accept      = instr_valid & instr_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      ctrl_reg     <= '0;
      beat_reg     <= '0;
      last_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      illegal_reg  <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (flush) begin
        state_reg   <= IDLE;
        ctrl_reg    <= '0;
        beat_reg    <= '0;
        last_reg    <= 1'b0;
        valid_reg   <= 1'b0;
        illegal_reg <= 1'b0;
      end else if (!stall || state_reg == IDLE) begin
        if (accept && dec_illegal) begin
          state_reg   <= IDLE;
          ctrl_reg    <= '0;
          beat_reg    <= '0;
          last_reg    <= 1'b0;
          valid_reg   <= 1'b0;
          illegal_reg <= 1'b1;
        end else if (accept) begin
          state_reg   <= dec.vector_op ? VECTOR : SCALAR;
          ctrl_reg    <= dec;
          beat_reg    <= '0;
          last_reg    <= !dec.vector_op || (BEATS == 1);
          valid_reg   <= 1'b1;
          illegal_reg <= 1'b0;
        end else if (state_reg == VECTOR && !last_reg) begin
          beat_reg <= beat_reg + BW'(1);
          last_reg <= ((beat_reg + BW'(1)) == LAST_IDX);
        end else begin
          // Last beat retired (or idle) with nothing new accepted.
          state_reg   <= IDLE;
          ctrl_reg    <= '0;
          beat_reg    <= '0;
          last_reg    <= 1'b0;
          valid_reg   <= 1'b0;
          illegal_reg <= 1'b0;
        end
      end
    end
  end

  assign ctrl_valid = valid_reg;
  assign JumpI      = ctrl_reg.jump_i;
  assign JumpCI     = ctrl_reg.jump_ci;
  assign JumpCD     = ctrl_reg.jump_cd;
  assign MemToReg   = ctrl_reg.mem_to_reg;
  assign MemWrite   = ctrl_reg.mem_write;
  assign ImmSrc     = ctrl_reg.imm_src;
  assign VectorOp   = ctrl_reg.vector_op;
  assign ALUSrc1    = ctrl_reg.alu_src1;
  assign ALUSrc2    = ctrl_reg.alu_src2;
  assign RegVWrite  = ctrl_reg.reg_v_write;
  assign RegSWrite  = ctrl_reg.reg_s_write;
  assign ALUOp      = ctrl_reg.alu_op;
  assign ALUSrc3    = ctrl_reg.alu_src3;
  assign beat_idx   = beat_reg;
  assign last_beat  = last_reg;
  assign illegal    = illegal_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes expected beats on acceptance,
// a negedge monitor compares and retires them as the DUT presents its outputs.
module tb_control_sequencer;

  localparam int VLEN  = 16;
  localparam int LANES = 4;
  localparam int BEATS = VLEN / LANES;
  localparam int BW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    instruction_type;
  logic [1:0]    func;
  logic          imm;
  logic          vector;
  logic          instr_valid;
  logic          instr_ready;
  logic          stall;
  logic          flush;
  logic          ctrl_valid;
  logic          JumpI, JumpCI, JumpCD, MemToReg, MemWrite, ImmSrc, VectorOp;
  logic          ALUSrc1, ALUSrc2, RegVWrite, RegSWrite;
  logic [1:0]    ALUOp, ALUSrc3;
  logic [BW-1:0] beat_idx;
  logic          last_beat;
  logic          illegal;

  control_sequencer #(.VLEN(VLEN), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .instruction_type(instruction_type), .func(func), .imm(imm), .vector(vector),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .stall(stall), .flush(flush), .ctrl_valid(ctrl_valid),
    .JumpI(JumpI), .JumpCI(JumpCI), .JumpCD(JumpCD), .MemToReg(MemToReg),
    .MemWrite(MemWrite), .ImmSrc(ImmSrc), .VectorOp(VectorOp), .ALUSrc1(ALUSrc1),
    .ALUSrc2(ALUSrc2), .RegVWrite(RegVWrite), .RegSWrite(RegSWrite),
    .ALUOp(ALUOp), .ALUSrc3(ALUSrc3), .beat_idx(beat_idx), .last_beat(last_beat),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ill;
    logic [14:0]   ctrl;
    logic [BW-1:0] idx;
    logic          last;
    int            acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   m_rem = 0;
  logic m_ready_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference decode straight from the instruction table: {illegal, controls}.
  function automatic logic [15:0] ref_decode(input logic [1:0] t, input logic [1:0] f,
                                             input logic im, input logic ve);
    logic ji, jci, jcd, m2r, mw, isrc, vop, a1, a2, rv, rs, bad;
    logic [1:0] aop, a3;
    {ji, jci, jcd, m2r, mw, isrc, vop, a1, a2, rv, rs, bad} = '0;
    aop = 2'b00;
    a3  = 2'b00;
    if (t == 2'd3) bad = 1'b1;
    else if (t == 2'd0) begin
      if (f == 2'd0 && !im) begin jci = 1'b1; isrc = 1'b1; a3 = 2'd3; aop = 2'd1; end
      else if (f == 2'd0 && im) ji = 1'b1;
      else if (f == 2'd1 && !im) begin jcd = 1'b1; isrc = 1'b1; a3 = 2'd3; aop = 2'd1; end
      else bad = 1'b1;
    end else if (t == 2'd1) begin
      if (f >= 2'd2) bad = 1'b1;
      else begin
        isrc = 1'b1; a3 = 2'd2; a1 = ve; vop = ve;
        if (f == 2'd0) mw = 1'b1;
        else begin m2r = 1'b1; rs = !ve; rv = ve; end
      end
    end else begin
      if (!im) begin
        if (f == 2'd3 || (f == 2'd2 && !ve)) bad = 1'b1;
        else begin a3 = 2'd1; aop = f; a2 = ve; vop = ve; rs = !ve; rv = ve; end
      end else if (ve) bad = 1'b1;
      else begin a3 = 2'd2; isrc = 1'b1; rs = 1'b1; aop = f; end
    end
    return {bad, ji, jci, jcd, m2r, mw, isrc, vop, a1, a2, rv, rs, aop, a3};
  endfunction

  // Drive one cycle of inputs (called at posedge+1), update the model, check instr_ready.
  task automatic step(input logic r, input logic v, input logic [1:0] t, input logic [1:0] f,
                      input logic im, input logic ve, input logic st, input logic fl,
                      output logic acc);
    logic rdy;
    logic [15:0] d;
    int n;
    rst = r; instr_valid = v; instruction_type = t; func = f;
    imm = im; vector = ve; stall = st; flush = fl;
    rdy = m_ready_en && (m_rem == 0 || (!st && m_rem == 1));
    acc = r && !fl && v && rdy;
    if (!r || fl) m_rem = 0;
    else if (!(st && m_rem > 0)) begin
      if (acc) begin
        d = ref_decode(t, f, im, ve);
        $display("cyc %0d accept type=%b func=%b imm=%b vec=%b illegal=%b", cyc, t, f, im, ve, d[15]);
        if (d[15]) begin
          exp_q.push_back('{1'b1, 15'd0, '0, 1'b1, cyc});
          m_rem = 0;
        end else begin
          n = d[8] ? BEATS : 1;
          for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, d[14:0], BW'(i), (i == n - 1), cyc});
          m_rem = n;
        end
      end else if (m_rem > 0) m_rem--;
    end
    m_ready_en = r;
    @(negedge clk);
    n_checks++;
    if (instr_ready === rdy) n_pass++;
    else $display("FAIL instr_ready cyc=%0d got=%b want=%b", cyc, instr_ready, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, a);
  endtask

  // Offer an instruction until accepted (bounded).
  task automatic issue(input logic [1:0] t, input logic [1:0] f, input logic im, input logic ve);
    logic a;
    int tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 20) begin
      step(1'b1, 1'b1, t, f, im, ve, 1'b0, 1'b0, a);
      tries++;
    end
    if (!a) begin
      n_checks++;
      $display("FAIL issue_timeout cyc=%0d got=not_accepted want=accepted", cyc);
    end
  endtask

  // Monitor: compare presented outputs with the scoreboard front, retire on handshake.
  always @(negedge clk) begin : monitor
    logic due;
    exp_t e;
    logic [19:0] exp_v, act_v;
    int a;
    if (cyc >= 1) begin
      due = (exp_q.size() > 0) && (exp_q[0].acc < cyc);
      exp_v = '0;
      if (due) begin
        e = exp_q[0];
        exp_v = e.ill ? {1'b0, 1'b1, 18'd0} : {1'b1, 1'b0, e.ctrl, e.idx, e.last};
      end
      act_v = {ctrl_valid, illegal, JumpI, JumpCI, JumpCD, MemToReg, MemWrite, ImmSrc,
               VectorOp, ALUSrc1, ALUSrc2, RegVWrite, RegSWrite, ALUOp, ALUSrc3,
               beat_idx, last_beat};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL outputs cyc=%0d got=%b want=%b", cyc, act_v, exp_v);
      if (due) begin
        if (!rst) exp_q.delete();
        else if (flush) begin
          a = e.acc;
          while (exp_q.size() > 0 && exp_q[0].acc == a) void'(exp_q.pop_front());
        end else if (e.ill || !stall) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic a;
    rst = 1'b0; instr_valid = 1'b1; instruction_type = 2'd1; func = 2'd1;
    imm = 1'b0; vector = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    // Reset held with an instruction offered, then released.
    step(1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, a);
    idle(1);
    // Scalar load.
    issue(2'd1, 2'd1, 1'b0, 1'b0);
    idle(2);
    // Vector add followed by a queued scalar sub with no bubble.
    issue(2'd2, 2'd0, 1'b0, 1'b1);
    issue(2'd2, 2'd1, 1'b0, 1'b0);
    idle(2);
    // Stall 3 cycles on beat 1.
    issue(2'd2, 2'd0, 1'b0, 1'b1);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, a);
    idle(4);
    // Flush on beat 2 with an instruction offered.
    issue(2'd2, 2'd0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, a);
    idle(2);
    // Illegal encodings.
    issue(2'd3, 2'd0, 1'b0, 1'b0);
    issue(2'd2, 2'd0, 1'b1, 1'b1);
    idle(2);
    // Reset in the middle of a vector load.
    issue(2'd1, 2'd1, 1'b0, 1'b1);
    idle(1);
    step(1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    idle(3);
    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 70),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 5), a);
    end
    idle(8);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d_pending want=0_pending", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Registered, multi-beat successor to the combinational instruction decoder of the vector core. It decodes the same instruction fields into datapath control signals and registers them. Vector operations are sequenced over VLEN/LANES beats with an element-group index. Upstream fetch and downstream execute connect through a valid/ready handshake with stall and flush. It sits between the decode stage register and the execute stage.

## Interface
- VLEN, default 16: elements per vector register.
- LANES, default 4: elements processed per beat. LANES must divide VLEN. BEATS = VLEN/LANES, BEATS ≥ 1.
- BW, default $clog2(BEATS) (1 when BEATS=1): beat index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- instruction_type  in  2  instruction class.
- func  in  2  function field.
- imm  in  1  immediate flag.
- vector  in  1  vector flag.
- instr_valid  in  1  instruction fields valid.
- instr_ready  out  1  instruction accepted on this edge if instr_valid.
- stall  in  1  execute cannot take the current beat; hold outputs.
- flush  in  1  discard the held operation and the instruction offered this cycle.
- ctrl_valid  out  1  control outputs describe a live beat.
- JumpI, JumpCI, JumpCD, MemToReg, MemWrite, ImmSrc, VectorOp, ALUSrc1, ALUSrc2, RegVWrite, RegSWrite  out  1 each  datapath controls.
- ALUOp, ALUSrc3  out  2 each  datapath controls.
- beat_idx  out  BW  element group of the current beat, 0..BEATS-1.
- last_beat  out  1  current beat is the final beat of the operation.
- illegal  out  1  one-cycle pulse: the accepted instruction was undefined.

## Operation
Decode (unlisted controls = 0):
- type 00, func 00, imm 0: JumpCI=1, ImmSrc=1, ALUSrc3=11, ALUOp=01.
- type 00, func 00, imm 1: JumpI=1, ALUSrc3=00, ALUOp=00.
- type 00, func 01, imm 0: JumpCD=1, ImmSrc=1, ALUSrc3=11, ALUOp=01.
- type 01: ImmSrc=1, ALUSrc3=10, ALUOp=00, ALUSrc1=vector, VectorOp=vector.
  - func 00 (store): MemWrite=1.
  - func 01 (load): MemToReg=1, RegSWrite=~vector, RegVWrite=vector.
- type 10, imm 0: ALUSrc3=01, ALUOp=func, ALUSrc2=vector, VectorOp=vector, RegSWrite=~vector, RegVWrite=vector.
- type 10, imm 1, vector 0: ALUSrc3=10, ImmSrc=1, RegSWrite=1, ALUOp=func.
- Illegal: type 11; type 00 with func 1x or (func 01, imm 1); type 01 with func 1x; type 10, imm 0 with func 11 or (func 10, vector 0); type 10, imm 1, vector 1.
  - Accepted like any instruction; illegal=1 for one cycle.
  - No beat issued: ctrl_valid stays 0.

FSM states IDLE, SCALAR, VECTOR:
- Acceptance is instr_valid & instr_ready. Next state is SCALAR if VectorOp=0, else VECTOR; beat_idx=0. Illegal goes to IDLE.
- SCALAR: one beat, last_beat=1.
- VECTOR: beat_idx advances by 1 on each edge with stall=0. last_beat=1 when beat_idx=BEATS-1. The advance after the last beat leaves the state.
- instr_ready = (state==IDLE) | (~stall & last_beat). This allows back-to-back issue with no bubble.
- If no instruction is accepted when the last beat retires, go to IDLE.
- All control outputs, beat_idx and last_beat are forced 0 whenever ctrl_valid=0.
- stall=1: every output register holds; beat_idx does not advance. Stall in IDLE has no effect; instr_ready stays 1.
- flush=1: next state IDLE, ctrl_valid=0, beat_idx=0, illegal=0.
  - Any instruction offered that cycle is dropped.
  - flush overrides stall and acceptance.

## Timing
- Reset (rst=0 at an edge): state IDLE and every output 0, including instr_ready, ctrl_valid, illegal and beat_idx. instr_ready rises 1 the cycle rst=1 is sampled.
- Latency: accept at edge N gives ctrl_valid=1 with decoded controls during cycle N+1.
- Vector op occupancy is BEATS unstalled cycles; each stall cycle adds 1. BEATS=1 behaves exactly like scalar.
- instr_ready is combinational from state, stall and last_beat only; it does not depend on instr_valid.
- illegal is asserted in cycle N+1 for an illegal accept at edge N.
- Reset mid-operation aborts the operation immediately; no partial beat is retained.

## Test plan
- Reset: hold rst=0 for 2 cycles with instr_valid=1 → all outputs 0. After release, instr_ready=1 and ctrl_valid=0.
- Scalar load (type 01, func 01, vector 0) accepted at edge N → cycle N+1: ctrl_valid=1, MemToReg=1, RegSWrite=1, ImmSrc=1, ALUSrc3=10, last_beat=1, instr_ready=1.
- Vector add (type 10, func 00, imm 0, vector 1), VLEN=16, LANES=4 → 4 beats with beat_idx 0,1,2,3, RegVWrite=1, ALUSrc2=1. instr_ready=0 for beats 0-2 and 1 at beat 3. A queued scalar sub issues the next cycle with no bubble.
- Stall 3 cycles during vector beat_idx=1 → outputs frozen for 3 cycles, beat_idx stays 1. Total occupancy is 7 cycles.
- Flush during vector beat 2 with instr_valid=1 → next cycle ctrl_valid=0 and all controls 0. The offered instruction never appears.
- Illegal type 11, then type 10 imm 1 vector 1 → illegal pulses one cycle each, ctrl_valid stays 0 and instr_ready stays 1.
